// File: rtl/sram_responder_if.sv
// Asynchronous SRAM pin bundle between an SRAM initiator and the sram_responder emulator.
// The bidirectional data bus is a plain inout port of the responder.
interface sram_responder_if #(
    parameter int pADDR_WIDTH = 20
);
    logic                   cen;
    logic                   wen;
    logic                   oen;
    logic                   ubn;
    logic                   lbn;
    logic [pADDR_WIDTH-1:0] addr;
    logic                   data_oe;

    modport master (
        output cen, wen, oen, ubn, lbn, addr,
        input  data_oe
    );

    modport slave (
        input  cen, wen, oen, ubn, lbn, addr,
        output data_oe
    );
endinterface

// File: rtl/sram_responder.sv
// FPGA-side asynchronous SRAM emulation backed by block RAM. It synchronizes the pins,
// serves reads and writes, flags cen/wen/oen all low, and counts completed accesses.
module sram_responder #(
    parameter int pDATA_WIDTH     = 8,
    parameter int pADDR_WIDTH     = 20,
    parameter int pMEM_ADDR_WIDTH = 10,
    parameter int pREAD_LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_responder_if.slave        bus,
    inout  wire  [pDATA_WIDTH-1:0] data_io,
    input  logic                   clear_err_i,
    output logic                   busy_o,
    output logic                   protocol_err_o,
    output logic [31:0]            write_count_o,
    output logic [31:0]            read_count_o
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_RWAIT  = 2'd2;
    localparam logic [1:0] ST_RDRIVE = 2'd3;

    localparam int          SYNC_W    = 5 + pADDR_WIDTH + pDATA_WIDTH;
    localparam logic [SYNC_W-1:0] SYNC_IDLE = {5'b11111, {(pADDR_WIDTH + pDATA_WIDTH){1'b0}}};
    localparam logic [3:0]  LAT_C     = 4'(pREAD_LATENCY);

    logic [SYNC_W-1:0]          pins_s;
    logic [SYNC_W-1:0]          sync1_q, sync2_q;
    logic                       s_cen, s_wen, s_oen, s_ubn, s_lbn;
    logic [pADDR_WIDTH-1:0]     s_addr;
    logic [pDATA_WIDTH-1:0]     s_data;

    logic [1:0]                 state_q, state_d;
    logic [3:0]                 lat_cnt_q, lat_cnt_d;
    logic [pMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [pDATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                       wr_lane_q, wr_lane_d;
    logic                       data_oe_q, data_oe_d;
    logic                       busy_q, busy_d;
    logic                       perr_q, perr_d;
    logic [31:0]                wcnt_q, wcnt_d;
    logic [31:0]                rcnt_q, rcnt_d;
    logic [pADDR_WIDTH-1:0]     prev_addr_q;
    logic [pDATA_WIDTH-1:0]     dout_q;
    logic [pDATA_WIDTH-1:0]     mem_q [0:(2**pMEM_ADDR_WIDTH)-1];
    logic                       mem_we_s;
    logic                       all_low_s;
    logic                       rd_stop_s;

    assign pins_s = {bus.cen, bus.wen, bus.oen, bus.ubn, bus.lbn, bus.addr, data_io};
    assign {s_cen, s_wen, s_oen, s_ubn, s_lbn, s_addr, s_data} = sync2_q;

    assign all_low_s = ~s_cen & ~s_wen & ~s_oen;
    assign rd_stop_s = s_cen | s_oen | ~s_wen;

    // Two-flop synchronizer for every pin, including the data bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
        end else begin
            sync1_q <= pins_s;
            sync2_q <= sync1_q;
        end
    end

    // Block RAM: contents survive reset; reads are registered and run every cycle.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
        dout_q <= mem_q[s_addr[pMEM_ADDR_WIDTH-1:0]];
    end

    // Access FSM, counters and sticky protocol error.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_lane_d = wr_lane_q;
        data_oe_d = data_oe_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        mem_we_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!s_cen && !s_wen) begin
                    state_d   = ST_WRITE;
                    wr_addr_d = s_addr[pMEM_ADDR_WIDTH-1:0];
                    wr_data_d = s_data;
                    wr_lane_d = ~(s_ubn & s_lbn);
                end else if (!s_cen && !s_oen) begin
                    state_d   = ST_RWAIT;
                    lat_cnt_d = 4'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // The exit cycle commits what was sampled while both enables were still low.
                if (s_cen || s_wen) begin
                    state_d = ST_IDLE;
                    if (wr_lane_q) begin
                        mem_we_s = 1'b1;
                        wcnt_d   = wcnt_q + 32'd1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end else begin
                    wr_addr_d = s_addr[pMEM_ADDR_WIDTH-1:0];
                    wr_data_d = s_data;
                    wr_lane_d = ~(s_ubn & s_lbn);
                end
            end
            ST_RWAIT: begin
                if (rd_stop_s) begin
                    state_d = ST_IDLE;
                end else if (lat_cnt_q == LAT_C) begin
                    state_d   = ST_RDRIVE;
                    data_oe_d = 1'b1;
                    rcnt_d    = rcnt_q + 32'd1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            ST_RDRIVE: begin
                if (rd_stop_s) begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                end else if (s_addr != prev_addr_q) begin
                    rcnt_d = rcnt_q + 32'd1;
                end else begin
                    rcnt_d = rcnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                data_oe_d = 1'b0;
            end
        endcase

        if (all_low_s) begin
            perr_d    = 1'b1;
            data_oe_d = 1'b0;
        end else if (clear_err_i) begin
            perr_d = 1'b0;
        end else begin
            perr_d = perr_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 4'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_lane_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            perr_q      <= 1'b0;
            wcnt_q      <= 32'd0;
            rcnt_q      <= 32'd0;
            prev_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_lane_q   <= wr_lane_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            perr_q      <= perr_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            prev_addr_q <= s_addr;
        end
    end

    assign data_io        = data_oe_q ? dout_q : {pDATA_WIDTH{1'bz}};
    assign bus.data_oe    = data_oe_q;
    assign busy_o         = busy_q;
    assign protocol_err_o = perr_q;
    assign write_count_o  = wcnt_q;
    assign read_count_o   = rcnt_q;
endmodule
